spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one SPI byte engine (mode 0-3 master, 8-bit) between two requesters.
- Latches a multi-byte transaction from the granted requester and drives that requester's active-low chip select.
- Feeds tx bytes one at a time to the engine and returns each rx byte tagged with its owner.
- Sits between the system bus clients and the SPI master engine.

Parameters:
- CS_SETUP_CYC, 2: clock cycles from cs_n assertion to the first byte launch (1..15).
- CS_HOLD_CYC, 2: clock cycles from the last byte done to cs_n deassertion (1..15).
- GAP_CYC, 1: idle cycles between consecutive bytes of one transaction (0..15).
- TIMEOUT_CYC, 255: maximum cycles to wait for engine byte completion before aborting (1..255).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester transaction request; bit i = requester i.
- req0_len  in  4  requester 0 byte count; 0 means 16.
- req1_len  in  4  requester 1 byte count; 0 means 16.
- req0_tx_data  in  8  requester 0 current tx byte.
- req1_tx_data  in  8  requester 1 current tx byte.
- grant  out  2  one-hot owner of the engine; 0 when idle.
- tx_pop  out  2  one-cycle pulse: owner's current tx byte consumed; the requester presents the next byte by the next LOAD.
- rx_byte  out  8  received byte.
- rx_valid  out  1  one-cycle pulse: rx_byte valid.
- rx_owner  out  1  requester index for rx_byte.
- done  out  2  one-cycle pulse at transaction end.
- err  out  2  one-cycle pulse with done when the transaction was aborted on timeout.
- cs_n  out  2  active-low chip selects; at most one low.
- spi_send_data  out  1  one-cycle launch pulse to the engine.
- spi_data_into_sys  out  8  byte to the engine; valid with spi_send_data.
- spi_byte_done  in  1  engine pulse: byte shifted; spi_rx_byte valid.
- spi_rx_byte  in  8  byte received by the engine.

Behaviour:
- Reset: state IDLE, grant=0, cs_n=2'b11, all pulses 0, rx_byte=0, rx_owner=0, rr_last=1 so requester 0 wins first. Reset mid-transaction aborts immediately; no done or err is issued.
- IDLE:
  - If any req_valid is set, grant the requester per round-robin. When both are valid, the requester != rr_last wins.
  - In the same edge: latch len (0 becomes 16) into a 5-bit remaining count, set grant, drive that cs_n low, set rr_last to the winner, go to CS_SETUP.
- CS_SETUP: count CS_SETUP_CYC cycles, then go to LOAD.
- LOAD (one cycle):
  - spi_send_data=1 and spi_data_into_sys = owner's tx_data, sampled this cycle.
  - tx_pop[owner]=1.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - On spi_byte_done: the next cycle has rx_byte=spi_rx_byte, rx_valid=1, rx_owner=owner. Decrement remaining.
  - If remaining was 1, go to CS_HOLD. Otherwise go to GAP, or directly to LOAD when GAP_CYC=0.
  - If the counter reaches TIMEOUT_CYC without done, set the abort flag and go to CS_HOLD.
- GAP: count GAP_CYC cycles, then go to LOAD.
- CS_HOLD: count CS_HOLD_CYC cycles, then go to DONE.
- DONE (one cycle):
  - cs_n returns to 11 and grant to 0.
  - done[owner]=1; err[owner]=abort flag; clear the abort flag.
  - Go to IDLE; arbitration may grant on the following edge.
- Boundary rules:
  - spi_byte_done outside WAIT is ignored.
  - req_valid and len changes after grant are ignored until DONE.
  - A requester still holding req_valid high in the cycle after done is a new request, arbitrated normally.
- Latency:
  - Grant edge to first spi_send_data = CS_SETUP_CYC+1 cycles.
  - Byte done to next spi_send_data = GAP_CYC+1 cycles.
  - Last byte done to done pulse = CS_HOLD_CYC+1 cycles.
- Counters are 4-bit for setup/hold/gap and 8-bit for timeout; no wrap is possible within the stated ranges.

Test Plan:
- req_valid=01, req0_len=2, tx bytes A5 then 3C; engine returns done 20 cycles after each launch with rx 11 and 22.
  Expect: cs_n[0] low; launches at the stated latencies with data A5 then 3C; two tx_pop; rx_valid with 11 then 22, rx_owner=0; done=01, err=0; cs_n=11.
- req_valid=11 held continuously, both len=1.
  Expect: grants alternate 01, 10, 01; cs_n never has both bits low; each done pulses once per transaction.
- req1_len=0.
  Expect: exactly 16 spi_send_data pulses and 16 rx_valid pulses before done=10.
- Engine never returns spi_byte_done, len=3.
  Expect: after 255 WAIT cycles, CS_HOLD then done=01 with err=01; only one launch; next request served normally.
- Reset asserted during WAIT of byte 2 of 4.
  Expect: next cycle cs_n=11, grant=0, no done or err; a fresh request then starts from CS_SETUP.
- Stray spi_byte_done in IDLE and GAP.
  Expect: no rx_valid and no change to the remaining count.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sequencer sharing one SPI byte engine between two requesters.
module spi_txn_arbiter #(
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int GAP_CYC      = 1,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [3:0] req0_len,
  input  logic [3:0] req1_len,
  input  logic [7:0] req0_tx_data,
  input  logic [7:0] req1_tx_data,
  output logic [1:0] grant,
  output logic [1:0] tx_pop,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_owner,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic [1:0] cs_n,
  output logic       spi_send_data,
  output logic [7:0] spi_data_into_sys,
  input  logic       spi_byte_done,
  input  logic [7:0] spi_rx_byte
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_GAP, S_HOLD, S_DONE} state_t;
  localparam logic [3:0] SETUP_END = 4'(CS_SETUP_CYC - 1);
  localparam logic [3:0] HOLD_END  = 4'(CS_HOLD_CYC - 1);
  localparam logic [3:0] GAP_END   = 4'(GAP_CYC - 1);
  localparam logic [7:0] TO_END    = 8'(TIMEOUT_CYC - 1);
  state_t     r_state;
  logic       r_owner, r_rr_last, r_abort;
  logic [4:0] r_rem;
  logic [3:0] r_cnt;
  logic [7:0] r_to;
  logic       w_pick, w_active;
  logic [3:0] w_len;
  logic [1:0] w_onehot;
  // With both requesting, whoever did not win last time goes next.
  assign w_pick            = (req_valid == 2'b11) ? ~r_rr_last : req_valid[1];
  assign w_len             = w_pick ? req1_len : req0_len;
  assign w_onehot          = r_owner ? 2'b10 : 2'b01;
  assign w_active          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign grant             = w_active ? w_onehot : 2'b00;
  assign cs_n              = ~grant;
  assign spi_send_data     = (r_state == S_LOAD);
  assign spi_data_into_sys = r_owner ? req1_tx_data : req0_tx_data;
  assign tx_pop            = spi_send_data ? w_onehot : 2'b00;
  assign done              = (r_state == S_DONE) ? w_onehot : 2'b00;
  assign err               = (r_state == S_DONE && r_abort) ? w_onehot : 2'b00;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_abort   <= 1'b0;
      r_rem     <= 5'd0;
      r_cnt     <= 4'd0;
      r_to      <= 8'd0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'd0;
      rx_owner  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_owner   <= w_pick;
          r_rr_last <= w_pick;
          r_rem     <= {w_len == 4'd0, w_len};
          r_cnt     <= 4'd0;
          r_state   <= S_SETUP;
        end
        S_SETUP: if (r_cnt == SETUP_END) begin
          r_cnt   <= 4'd0;
          r_state <= S_LOAD;
        end else r_cnt <= r_cnt + 4'd1;
        S_LOAD: begin
          r_to    <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (spi_byte_done) begin
          rx_valid <= 1'b1;
          rx_byte  <= spi_rx_byte;
          rx_owner <= r_owner;
          r_rem    <= r_rem - 5'd1;
          r_cnt    <= 4'd0;
          r_state  <= (r_rem == 5'd1) ? S_HOLD : (GAP_CYC == 0 ? S_LOAD : S_GAP);
        end else if (r_to == TO_END) begin
          r_abort <= 1'b1;
          r_cnt   <= 4'd0;
          r_state <= S_HOLD;
        end else r_to <= r_to + 8'd1;
        S_GAP: if (r_cnt == GAP_END) begin
          r_cnt   <= 4'd0;
          r_state <= S_LOAD;
        end else r_cnt <= r_cnt + 4'd1;
        S_HOLD: if (r_cnt == HOLD_END) begin
          r_cnt   <= 4'd0;
          r_state <= S_DONE;
        end else r_cnt <= r_cnt + 4'd1;
        S_DONE: begin
          r_abort <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed tests for spi_txn_arbiter with default parameters.
module tb_spi_txn_arbiter;
  logic       clock = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req0_len = 4'd0, req1_len = 4'd0;
  logic [7:0] req0_tx_data = 8'd0, req1_tx_data = 8'd0;
  logic       spi_byte_done = 1'b0;
  logic [7:0] spi_rx_byte = 8'd0;
  logic [1:0] grant, tx_pop, done, err, cs_n;
  logic [7:0] rx_byte, spi_data_into_sys;
  logic       rx_valid, rx_owner, spi_send_data;
  int n_cmp = 0, n_bad = 0;
  int n_send = 0, n_rxv = 0, n_pop = 0, n_done = 0, cs_bad = 0;

  spi_txn_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_tx_data(req0_tx_data), .req1_tx_data(req1_tx_data),
    .grant(grant), .tx_pop(tx_pop), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_owner(rx_owner), .done(done), .err(err), .cs_n(cs_n),
    .spi_send_data(spi_send_data), .spi_data_into_sys(spi_data_into_sys),
    .spi_byte_done(spi_byte_done), .spi_rx_byte(spi_rx_byte)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (!reset) begin
    n_send <= n_send + int'(spi_send_data);
    n_rxv  <= n_rxv + int'(rx_valid);
    n_pop  <= n_pop + $countones(tx_pop);
    n_done <= n_done + $countones(done);
    if (cs_n == 2'b00) cs_bad <= cs_bad + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_send(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (spi_send_data) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_done(input int max, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < max; i++) begin
      if (|done) begin
        ok = 1'b1;
        break;
      end
      tick;
      cyc++;
    end
  endtask

  task automatic engine_byte(input int d, input logic [7:0] rx);
    repeat (d) tick;
    spi_byte_done = 1'b1;
    spi_rx_byte = rx;
    tick;
    spi_byte_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    n_cmp++;
    if ({grant, cs_n, done, err, tx_pop} !== {2'b00, 2'b11, 2'b00, 2'b00, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got grant=%b cs_n=%b done=%b err=%b pop=%b, required 00 11 00 00 00", grant, cs_n, done, err, tx_pop);
    end
    n_cmp++;
    if ({rx_valid, rx_owner, rx_byte, spi_send_data} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_rx: got rxv=%b owner=%b rx=%h send=%b, required 0 0 00 0", rx_valid, rx_owner, rx_byte, spi_send_data);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int p0;
    p0 = n_pop;
    req0_len = 4'd2;
    req0_tx_data = 8'hA5;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    n_cmp++;
    if ({grant, cs_n} !== {2'b01, 2'b10}) begin
      n_bad++;
      $display("FAIL single_grant: got grant=%b cs_n=%b, required 01 10", grant, cs_n);
    end
    tick;
    n_cmp++;
    if (spi_send_data !== 1'b0) begin
      n_bad++;
      $display("FAIL single_setup: got send=%b, required 0", spi_send_data);
    end
    tick;
    n_cmp++;
    if ({spi_send_data, spi_data_into_sys, tx_pop} !== {1'b1, 8'hA5, 2'b01}) begin
      n_bad++;
      $display("FAIL single_launch1: got send=%b data=%h pop=%b, required 1 a5 01", spi_send_data, spi_data_into_sys, tx_pop);
    end
    tick;
    req0_tx_data = 8'h3C;
    engine_byte(19, 8'h11);
    n_cmp++;
    if ({rx_valid, rx_owner, rx_byte} !== {1'b1, 1'b0, 8'h11}) begin
      n_bad++;
      $display("FAIL single_rx1: got rxv=%b owner=%b rx=%h, required 1 0 11", rx_valid, rx_owner, rx_byte);
    end
    tick;
    n_cmp++;
    if ({spi_send_data, spi_data_into_sys, tx_pop, rx_valid} !== {1'b1, 8'h3C, 2'b01, 1'b0}) begin
      n_bad++;
      $display("FAIL single_launch2: got send=%b data=%h pop=%b rxv=%b, required 1 3c 01 0", spi_send_data, spi_data_into_sys, tx_pop, rx_valid);
    end
    tick;
    engine_byte(19, 8'h22);
    n_cmp++;
    if ({rx_valid, rx_owner, rx_byte} !== {1'b1, 1'b0, 8'h22}) begin
      n_bad++;
      $display("FAIL single_rx2: got rxv=%b owner=%b rx=%h, required 1 0 22", rx_valid, rx_owner, rx_byte);
    end
    tick;
    n_cmp++;
    if ({done, cs_n} !== {2'b00, 2'b10}) begin
      n_bad++;
      $display("FAIL single_hold: got done=%b cs_n=%b, required 00 10", done, cs_n);
    end
    tick;
    n_cmp++;
    if ({done, err, cs_n, grant} !== {2'b01, 2'b00, 2'b11, 2'b00}) begin
      n_bad++;
      $display("FAIL single_done: got done=%b err=%b cs_n=%b grant=%b, required 01 00 11 00", done, err, cs_n, grant);
    end
    tick;
    n_cmp++;
    if ({done, n_pop - p0} !== {2'b00, 32'd2}) begin
      n_bad++;
      $display("FAIL single_end: got done=%b pops=%0d, required 00 and 2", done, n_pop - p0);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    bit ok;
    int cyc, d0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    d0 = n_done;
    req0_len = 4'd1;
    req1_len = 4'd1;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_send(20, ok);
      n_cmp++;
      if ({ok, grant} !== {1'b1, exp_g[i]}) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got launched=%b grant=%b, required 1 %b", i, ok, grant, exp_g[i]);
      end
      engine_byte(2, 8'(i));
      wait_done(20, ok, cyc);
      n_cmp++;
      if ({ok, done} !== {1'b1, exp_g[i]}) begin
        n_bad++;
        $display("FAIL rr_done%0d: got seen=%b done=%b, required 1 %b", i, ok, done, exp_g[i]);
      end
      if (i == 2) req_valid = 2'b00;
      tick;
    end
    tick;
    n_cmp++;
    if ({cs_bad, n_done - d0} !== {32'd0, 32'd3}) begin
      n_bad++;
      $display("FAIL rr_totals: got cs_both_low=%0d done_pulses=%0d, required 0 and 3", cs_bad, n_done - d0);
    end
  endtask

  task automatic test_len16;
    bit ok;
    int cyc, s0, r0;
    req1_len = 4'd0;
    req_valid = 2'b10;
    tick;
    req_valid = 2'b00;
    s0 = n_send;
    r0 = n_rxv;
    for (int i = 0; i < 16; i++) begin
      wait_send(10, ok);
      engine_byte(1, 8'(i + 16));
      n_cmp++;
      if ({ok, rx_valid, rx_owner, rx_byte} !== {1'b1, 1'b1, 1'b1, 8'(i + 16)}) begin
        n_bad++;
        $display("FAIL len16_byte%0d: got launched=%b rxv=%b owner=%b rx=%h, required 1 1 1 %h", i, ok, rx_valid, rx_owner, rx_byte, 8'(i + 16));
      end
    end
    wait_done(10, ok, cyc);
    n_cmp++;
    if ({ok, done, n_send - s0, n_rxv - r0} !== {1'b1, 2'b10, 32'd16, 32'd16}) begin
      n_bad++;
      $display("FAIL len16_done: got seen=%b done=%b sends=%0d rx=%0d, required 1 10 16 16", ok, done, n_send - s0, n_rxv - r0);
    end
    tick;
  endtask

  task automatic test_timeout;
    bit ok;
    int cyc, s0;
    req0_len = 4'd3;
    req_valid = 2'b01;
    s0 = n_send;
    tick;
    req_valid = 2'b00;
    wait_send(10, ok);
    wait_done(400, ok, cyc);
    n_cmp++;
    if ({ok, cyc} !== {1'b1, 32'd258}) begin
      n_bad++;
      $display("FAIL timeout_latency: got seen=%b cycles=%0d, required 1 and 258", ok, cyc);
    end
    n_cmp++;
    if ({done, err, n_send - s0} !== {2'b01, 2'b01, 32'd1}) begin
      n_bad++;
      $display("FAIL timeout_err: got done=%b err=%b sends=%0d, required 01 01 1", done, err, n_send - s0);
    end
    tick;
    req0_len = 4'd1;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    wait_send(10, ok);
    engine_byte(3, 8'h5A);
    wait_done(10, ok, cyc);
    n_cmp++;
    if ({ok, done, err, rx_byte} !== {1'b1, 2'b01, 2'b00, 8'h5A}) begin
      n_bad++;
      $display("FAIL timeout_recover: got seen=%b done=%b err=%b rx=%h, required 1 01 00 5a", ok, done, err, rx_byte);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc, d0;
    req0_len = 4'd4;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    wait_send(10, ok);
    engine_byte(2, 8'h01);
    wait_send(10, ok);
    tick;
    tick;
    d0 = n_done;
    reset = 1'b1;
    tick;
    n_cmp++;
    if ({cs_n, grant, done, err, spi_send_data} !== {2'b11, 2'b00, 2'b00, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_abort: got cs_n=%b grant=%b done=%b err=%b send=%b, required 11 00 00 00 0", cs_n, grant, done, err, spi_send_data);
    end
    reset = 1'b0;
    repeat (5) tick;
    n_cmp++;
    if (n_done - d0 !== 0) begin
      n_bad++;
      $display("FAIL rstmid_nodone: got done_pulses=%0d, required 0", n_done - d0);
    end
    req0_len = 4'd1;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    tick;
    n_cmp++;
    if ({grant, spi_send_data} !== {2'b01, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_setup: got grant=%b send=%b, required 01 0", grant, spi_send_data);
    end
    tick;
    n_cmp++;
    if (spi_send_data !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_launch: got send=%b, required 1", spi_send_data);
    end
    engine_byte(2, 8'h42);
    wait_done(10, ok, cyc);
    n_cmp++;
    if ({ok, done, err} !== {1'b1, 2'b01, 2'b00}) begin
      n_bad++;
      $display("FAIL rstmid_fresh: got seen=%b done=%b err=%b, required 1 01 00", ok, done, err);
    end
    tick;
  endtask

  task automatic test_stray;
    bit ok;
    int cyc, s0, r0;
    r0 = n_rxv;
    spi_rx_byte = 8'hEE;
    spi_byte_done = 1'b1;
    repeat (3) tick;
    spi_byte_done = 1'b0;
    n_cmp++;
    if ({rx_valid, n_rxv - r0} !== {1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL stray_idle: got rxv=%b rx_pulses=%0d, required 0 and 0", rx_valid, n_rxv - r0);
    end
    req0_len = 4'd2;
    req_valid = 2'b01;
    s0 = n_send;
    tick;
    req_valid = 2'b00;
    wait_send(10, ok);
    engine_byte(2, 8'h77);
    spi_rx_byte = 8'hEE;
    spi_byte_done = 1'b1;
    tick;
    spi_byte_done = 1'b0;
    n_cmp++;
    if ({spi_send_data, rx_valid} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL stray_gap: got send=%b rxv=%b, required 1 0", spi_send_data, rx_valid);
    end
    engine_byte(2, 8'h88);
    wait_done(10, ok, cyc);
    n_cmp++;
    if ({ok, done, rx_byte, n_send - s0, n_rxv - r0} !== {1'b1, 2'b01, 8'h88, 32'd2, 32'd2}) begin
      n_bad++;
      $display("FAIL stray_count: got seen=%b done=%b rx=%h sends=%0d rx_pulses=%0d, required 1 01 88 2 2", ok, done, rx_byte, n_send - s0, n_rxv - r0);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_len16;
    test_timeout;
    test_reset_mid;
    test_stray;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
